// File: rtl/sum_loop_controller_if.sv
// Signal bundle between sum_loop_controller and its host/datapath: start/abort
// handshake, loop-compare inputs, datapath enables and run status.
interface sum_loop_controller_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] i;
  logic [WIDTH-1:0] e;
  logic             Enable3;
  logic             Enable6;
  logic             Enable7;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] iter_count;
  logic [2:0]       state_dbg;

  modport master (
    output start, abort, i, e,
    input  Enable3, Enable6, Enable7, busy, done, error, iter_count, state_dbg
  );

  modport slave (
    input  start, abort, i, e,
    output Enable3, Enable6, Enable7, busy, done, error, iter_count, state_dbg
  );
endinterface

// File: rtl/sum_loop_controller.sv
// Control unit for the total_module summation datapath: init, loop while i < e,
// publish; with start/done handshake, abort and an iteration watchdog.
module sum_loop_controller #(
  parameter int WIDTH    = 32,
  parameter int CNT_W    = 16,
  parameter int MAX_ITER = 1000
) (
  input logic                  clk,
  input logic                  rst,
  sum_loop_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    CHECK  = 3'd2,
    ACCUM  = 3'd3,
    FINISH = 3'd4,
    ABORT  = 3'd5,
    DONE   = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] MaxIter = CNT_W'(MAX_ITER);

  state_e           state_q, state_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [WIDTH-1:0] iVal, eVal;
  logic             loopMore;

  assign iVal     = bus.i;
  assign eVal     = bus.e;
  assign loopMore = (iVal < eVal);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      error_q <= 1'b0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
      iter_q  <= iter_d;
    end
  end

  // The watchdog only trips when another iteration is actually wanted, so a
  // run whose bound equals MAX_ITER still finishes normally.
  always_comb begin
    state_d = state_q;
    error_d = error_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = INIT;
          error_d = 1'b0;
          iter_d  = '0;
        end
      end
      INIT:   state_d = CHECK;
      CHECK: begin
        if (bus.abort) begin
          state_d = ABORT;
        end else if (loopMore && (iter_q == MaxIter)) begin
          state_d = ABORT;
        end else if (loopMore) begin
          state_d = ACCUM;
        end else begin
          state_d = FINISH;
        end
      end
      ACCUM: begin
        if (iter_q != '1) begin
          iter_d = iter_q + CNT_W'(1);
        end
        state_d = bus.abort ? ABORT : CHECK;
      end
      FINISH: state_d = DONE;
      ABORT: begin
        error_d = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs: every enable is a pure decode of the state register.
  always_comb begin
    bus.Enable3    = 1'b0;
    bus.Enable6    = 1'b0;
    bus.Enable7    = 1'b0;
    bus.done       = 1'b0;
    bus.busy       = (state_q != IDLE);
    bus.error      = error_q;
    bus.iter_count = iter_q;
    bus.state_dbg  = state_q;
    case (state_q)
      INIT:    bus.Enable3 = 1'b1;
      ACCUM:   bus.Enable6 = 1'b1;
      FINISH:  bus.Enable7 = 1'b1;
      DONE:    bus.done    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sum_loop_controller.sv
// Bench for sum_loop_controller: behavioural total_module datapath plus a
// scoreboard of per-run expectations checked when done pulses.
module tb_sum_loop_controller;

  localparam int WIDTH    = 32;
  localparam int CNT_W    = 16;
  localparam int MAX_ITER = 25;

  typedef struct {
    int               accums;
    int               e7Cycle;
    int               doneCycle;
    logic             err;
    logic             publish;
    logic [WIDTH-1:0] result;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sum_loop_controller_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  sum_loop_controller #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .MAX_ITER(MAX_ITER)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Behavioural total_module: init loads e from dpBound, accumulate, publish.
  int unsigned      dpBound  = 20;
  logic [WIDTH-1:0] dpSum    = '0;
  logic [WIDTH-1:0] dpI      = '0;
  logic [WIDTH-1:0] dpE      = '0;
  logic [WIDTH-1:0] dpResult = '0;
  logic             dpReady  = 1'b0;

  always @(posedge clk) begin
    if (bus.Enable3) begin
      dpSum   <= '0;
      dpI     <= '0;
      dpE     <= WIDTH'(dpBound);
      dpReady <= 1'b0;
    end else if (bus.Enable6) begin
      dpSum <= dpSum + dpI;
      dpI   <= dpI + 1;
    end else if (bus.Enable7) begin
      dpResult <= dpSum;
      dpReady  <= 1'b1;
    end
  end

  assign bus.i = dpI;
  assign bus.e = dpE;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic exp_t predict(input int bound, input int abortAt);
    exp_t x;
    int   lim;
    lim = (bound < MAX_ITER) ? bound : MAX_ITER;
    if (abortAt > 0 && abortAt <= lim) begin
      x.accums = abortAt; x.err = 1'b1; x.publish = 1'b0;
      x.e7Cycle = 0; x.doneCycle = 2 * abortAt + 3;
    end else if (bound > MAX_ITER) begin
      x.accums = MAX_ITER; x.err = 1'b1; x.publish = 1'b0;
      x.e7Cycle = 0; x.doneCycle = 2 * MAX_ITER + 4;
    end else begin
      x.accums = bound; x.err = 1'b0; x.publish = 1'b1;
      x.e7Cycle = 2 * bound + 3; x.doneCycle = 2 * bound + 4;
    end
    x.result = WIDTH'((x.accums * (x.accums - 1)) / 2);
    return x;
  endfunction

  exp_t expQ[$];
  int   abortAt     = 0;
  int   edgeCnt     = 0;
  int   acceptEdge  = 0;
  int   acceptCount = 0;
  int   doneCount   = 0;
  bit   modelIdle   = 1'b1;
  bit   pendingIdle = 1'b0;
  bit   runActive   = 1'b0;
  int   e3Cycle     = 0;
  int   e6Count     = 0;
  int   e7Cycle     = 0;

  // Acceptance model: a start is taken on any edge where the controller idles.
  always @(posedge clk) begin
    edgeCnt++;
    if (rst) begin
      expQ.delete();
      modelIdle   = 1'b1;
      pendingIdle = 1'b0;
      runActive   = 1'b0;
    end else if (modelIdle && bus.start) begin
      expQ.push_back(predict(int'(dpBound), abortAt));
      acceptEdge = edgeCnt;
      modelIdle  = 1'b0;
      runActive  = 1'b1;
      e3Cycle    = 0;
      e6Count    = 0;
      e7Cycle    = 0;
      acceptCount++;
    end else if (pendingIdle) begin
      modelIdle   = 1'b1;
      pendingIdle = 1'b0;
    end
  end

  always @(negedge clk) begin
    int   c;
    exp_t x;
    if (!rst && runActive) begin
      c = edgeCnt - acceptEdge + 1;
      checkOutput("enableExcl", 64'($countones({bus.Enable3, bus.Enable6, bus.Enable7}) <= 1), 64'd1);
      if (c == 1) checkOutput("startClears", {bus.error, bus.iter_count}, 64'd0);
      if (bus.Enable3 && e3Cycle == 0) e3Cycle = c;
      if (bus.Enable6) e6Count++;
      if (bus.Enable7) e7Cycle = c;
      if (bus.done) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedDone", 64'd1, 64'd0);
        end else begin
          x = expQ.pop_front();
          checkOutput("doneCycle", 64'(c), 64'(x.doneCycle));
          checkOutput("enable3Cycle", 64'(e3Cycle), 64'd1);
          checkOutput("enable6Count", 64'(e6Count), 64'(x.accums));
          checkOutput("enable7Cycle", 64'(e7Cycle), 64'(x.e7Cycle));
          checkOutput("iterCount", 64'(bus.iter_count), 64'(x.accums));
          checkOutput("error", 64'(bus.error), 64'(x.err));
          checkOutput("busyAtDone", 64'(bus.busy), 64'd1);
          if (x.publish) begin
            checkOutput("result", 64'(dpResult), 64'(x.result));
            checkOutput("ready", 64'(dpReady), 64'd1);
          end
        end
        runActive   = 1'b0;
        pendingIdle = 1'b1;
        doneCount++;
      end
    end
  end

  task automatic waitDone(input int target);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      #2;
      if (doneCount >= target) return;
    end
    checkOutput("doneTimeout", 64'(doneCount), 64'(target));
  endtask

  task automatic applyStimulus(input int bound, input int abortCycle);
    int seen;
    @(negedge clk);
    dpBound   = bound;
    abortAt   = abortCycle;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (abortCycle > 0) begin
      seen = 0;
      for (int k = 0; k < 400 && seen < abortCycle; k++) begin
        if (k > 0) @(negedge clk);
        #1;
        if (bus.Enable6) seen++;
      end
      bus.abort = 1'b1;
      @(negedge clk);
      #1;
      bus.abort = 1'b0;
    end
  endtask

  initial begin
    int base;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("resetOutputs",
                {bus.Enable3, bus.Enable6, bus.Enable7, bus.busy, bus.done, bus.error,
                 bus.iter_count, bus.state_dbg}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(20, 0);
    waitDone(1);

    applyStimulus(0, 0);
    waitDone(2);

    applyStimulus(MAX_ITER + 15, 0);
    waitDone(3);
    @(negedge clk);
    #1;
    checkOutput("errorHoldIdle", {bus.busy, bus.error}, 64'd1);

    applyStimulus(MAX_ITER, 0);
    waitDone(4);

    applyStimulus(20, 5);
    abortAt = 0;
    waitDone(5);

    // Reset in the middle of cycle 10 of a run.
    applyStimulus(20, 0);
    repeat (9) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midRunReset",
                {bus.Enable3, bus.Enable6, bus.Enable7, bus.busy, bus.done, bus.error,
                 bus.iter_count, bus.state_dbg}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(20, 0);
    waitDone(6);

    // Start held high: back-to-back runs, mid-run start ignored.
    base = acceptCount;
    @(negedge clk);
    dpBound   = 4;
    bus.start = 1'b1;
    for (int k = 0; k < 200 && acceptCount < base + 3; k++) @(negedge clk);
    bus.start = 1'b0;
    checkOutput("heldStartRuns", 64'(acceptCount), 64'(base + 3));
    waitDone(9);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
